// File: rtl/gpr_move_sequencer.sv
// Register-to-register transfer sequencer for the GPR file: stages MOV, SWAP
// and ZERO through two 16-bit holding registers on the shared DATA bus.
module gpr_move_sequencer (
  input  logic        clk,
  input  logic        reset,
  inout  wire  [15:0] DATA,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_src,
  input  logic [2:0]  cmd_dst,
  output logic        GPR_in,
  output logic        GPR_out,
  output logic [2:0]  GPR_select,
  output logic [2:0]  Rd_1,
  output logic [2:0]  Rs_1,
  output logic        done,
  output logic        err,
  output logic [15:0] HOLD_OUT_A,
  output logic [15:0] HOLD_OUT_B
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
  // cmd_ready is high only in IDLE; the command fields are sampled only on that
  // edge, and a held cmd_valid while cmd_ready is low is simply ignored.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    DONE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_MOV  = 2'b00,
    OP_SWAP = 2'b01,
    OP_ZERO = 2'b10,
    OP_ILL  = 2'b11
  } op_t;

  localparam logic [2:0] SEL_R0 = 3'b000;
  localparam logic [2:0] SEL_RD = 3'b010;
  localparam logic [2:0] SEL_RS = 3'b100;

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [15:0] hold_a_q, hold_b_q;
  logic        drv_a_q, drv_b_q;
  logic        accept;

  logic        ready_d, done_d, err_d, gin_d, gout_d, drv_a_d, drv_b_d;
  logic [2:0]  sel_d;

  assign accept = (state_q == IDLE) && cmd_valid;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = op_t'(cmd_op);
          state_d = (op_t'(cmd_op) == OP_ILL) ? DONE : S1;
        end
      end
      S1:      state_d = S2;
      S2:      state_d = (op_q == OP_SWAP) ? S3 : DONE;
      S3:      state_d = S4;
      S4:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    ready_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    gin_d   = 1'b0;
    gout_d  = 1'b0;
    drv_a_d = 1'b0;
    drv_b_d = 1'b0;
    sel_d   = SEL_R0;
    case (state_d)
      IDLE: ready_d = 1'b1;
      S1: begin
        gout_d = 1'b1;
        sel_d  = (op_d == OP_ZERO) ? SEL_R0 : SEL_RS;
      end
      S2: begin
        sel_d = SEL_RD;
        if (op_d == OP_SWAP) begin
          gout_d = 1'b1;
        end else begin
          gin_d   = 1'b1;
          drv_a_d = 1'b1;
        end
      end
      S3: begin
        gin_d   = 1'b1;
        drv_a_d = 1'b1;
        sel_d   = SEL_RD;
      end
      S4: begin
        gin_d   = 1'b1;
        drv_b_d = 1'b1;
        sel_d   = SEL_RS;
      end
      DONE: begin
        done_d = 1'b1;
        err_d  = (op_d == OP_ILL);
      end
      default: ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_MOV;
      Rd_1       <= 3'd0;
      Rs_1       <= 3'd0;
      hold_a_q   <= 16'h0000;
      hold_b_q   <= 16'h0000;
      cmd_ready  <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      GPR_in     <= 1'b0;
      GPR_out    <= 1'b0;
      GPR_select <= SEL_R0;
      drv_a_q    <= 1'b0;
      drv_b_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      if (accept) begin
        Rd_1 <= cmd_dst;
        Rs_1 <= cmd_src;
      end
      // The register file drives DATA in S1 (and S2 of a SWAP); capture at the end.
      if (state_q == S1) hold_a_q <= DATA;
      if (state_q == S2 && op_q == OP_SWAP) hold_b_q <= DATA;
      cmd_ready  <= ready_d;
      done       <= done_d;
      err        <= err_d;
      GPR_in     <= gin_d;
      GPR_out    <= gout_d;
      GPR_select <= sel_d;
      drv_a_q    <= drv_a_d;
      drv_b_q    <= drv_b_d;
    end
  end

  assign DATA       = drv_a_q ? hold_a_q : (drv_b_q ? hold_b_q : 16'bz);
  assign HOLD_OUT_A = hold_a_q;
  assign HOLD_OUT_B = hold_b_q;

endmodule

// File: tb/tb_gpr_move_sequencer.sv
// Bench for gpr_move_sequencer: a register-file model on DATA, a command-level
// reference model producing per-cycle expectations, and directed commands.
module tb_gpr_move_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wire  [15:0] DATA;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_src, cmd_dst;
  logic        GPR_in, GPR_out, done, err;
  logic [2:0]  GPR_select, Rd_1, Rs_1;
  logic [15:0] HOLD_OUT_A, HOLD_OUT_B;

  gpr_move_sequencer dut (
    .clk(clk), .reset(reset), .DATA(DATA),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .GPR_in(GPR_in), .GPR_out(GPR_out), .GPR_select(GPR_select),
    .Rd_1(Rd_1), .Rs_1(Rs_1), .done(done), .err(err),
    .HOLD_OUT_A(HOLD_OUT_A), .HOLD_OUT_B(HOLD_OUT_B)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- register file environment ----------------
  logic [15:0] rf [8];
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_val;
  logic [2:0]  rf_addr;

  always_comb begin
    case (GPR_select)
      3'b010:  rf_addr = Rd_1;
      3'b100:  rf_addr = Rs_1;
      default: rf_addr = 3'd0;
    endcase
  end

  assign DATA = GPR_out ? ((rf_addr == 3'd0) ? 16'h0000 : rf[rf_addr]) : 16'bz;

  always @(posedge clk) begin
    if (ld_en && ld_addr != 3'd0) rf[ld_addr] <= ld_val;
    else if (GPR_in && rf_addr != 3'd0) rf[rf_addr] <= DATA;
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        ready, done, err, gin, gout;
    logic [2:0]  sel;
    logic        dchk;
    logic [15:0] dval, ha, hb;
    logic        wr;
    logic [2:0]  wa;
    logic [15:0] wv;
  } vec_t;

  vec_t        exp_q[$];
  logic [15:0] m_regs [8] = '{default: 16'h0000};
  logic [15:0] m_ha = 16'h0000, m_hb = 16'h0000;
  logic [2:0]  m_rd = 3'd0, m_rs = 3'd0;
  logic        started = 1'b0;
  logic        reg_chk = 1'b0;
  logic        was_empty;
  vec_t        head;

  // Expected per-cycle outputs of one command, from its register-level meaning.
  task automatic push_cmd(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d);
    vec_t v;
    logic [15:0] va, vb;
    va   = (op == 2'b10) ? 16'h0000 : m_regs[s];
    vb   = m_regs[d];
    m_rd = d;
    m_rs = s;
    v = '0; v.ha = m_ha; v.hb = m_hb;
    if (op == 2'b11) begin
      v.done = 1'b1; v.err = 1'b1; exp_q.push_back(v);
    end else if (op == 2'b01) begin
      v.gout = 1'b1; v.sel = 3'b100; v.dchk = 1'b1; v.dval = va; exp_q.push_back(v);
      v.sel = 3'b010; v.dval = vb; v.ha = va; exp_q.push_back(v);
      v.gout = 1'b0; v.gin = 1'b1; v.dval = va; v.hb = vb;
      v.wr = 1'b1; v.wa = d; v.wv = va; exp_q.push_back(v);
      v.sel = 3'b100; v.dval = vb; v.wa = s; v.wv = vb; exp_q.push_back(v);
      v = '0; v.done = 1'b1; v.ha = va; v.hb = vb; exp_q.push_back(v);
      m_ha = va; m_hb = vb;
    end else begin
      v.gout = 1'b1; v.sel = (op == 2'b10) ? 3'b000 : 3'b100;
      v.dchk = 1'b1; v.dval = va; exp_q.push_back(v);
      v.gout = 1'b0; v.gin = 1'b1; v.sel = 3'b010; v.ha = va;
      v.wr = 1'b1; v.wa = d; v.wv = va; exp_q.push_back(v);
      v = '0; v.done = 1'b1; v.ha = va; v.hb = m_hb; exp_q.push_back(v);
      m_ha = va;
    end
  endtask

  always @(posedge clk) begin
    was_empty = (exp_q.size() == 0);
    if (ld_en && ld_addr != 3'd0) m_regs[ld_addr] = ld_val;
    if (!was_empty) begin
      head = exp_q.pop_front();
      if (head.wr && head.wa != 3'd0) m_regs[head.wa] = head.wv;
    end
    if (reset) begin
      exp_q.delete();
      m_ha = 16'h0000; m_hb = 16'h0000; m_rd = 3'd0; m_rs = 3'd0;
      started = 1'b1;
    end else if (was_empty && cmd_valid) begin
      push_cmd(cmd_op, cmd_src, cmd_dst);
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    vec_t e;
    if (started) begin
      if (exp_q.size() > 0) e = exp_q[0];
      else begin
        e = '0; e.ready = 1'b1; e.ha = m_ha; e.hb = m_hb;
      end
      chk("ctrl{ready,done,err,in,out,sel}",
          {24'd0, cmd_ready, done, err, GPR_in, GPR_out, GPR_select},
          {24'd0, e.ready, e.done, e.err, e.gin, e.gout, e.sel});
      chk("addr{rd,rs}", {26'd0, Rd_1, Rs_1}, {26'd0, m_rd, m_rs});
      chk("hold{a,b}", {HOLD_OUT_A, HOLD_OUT_B}, {e.ha, e.hb});
      chk("in_out_exclusive", {31'd0, GPR_in & GPR_out}, 32'd0);
      if (e.dchk) chk("data_bus", {16'd0, DATA}, {16'd0, e.dval});
      if (reg_chk && exp_q.size() == 0)
        for (int i = 1; i < 8; i++) chk($sformatf("reg_r%0d", i), {16'd0, rf[i]}, {16'd0, m_regs[i]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load(input logic [2:0] a, input logic [15:0] v);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_val = v;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", {31'd0, cmd_ready}, 32'd1);
  endtask

  // Issue one command and return the cycle index (1 = first after acceptance) of done.
  task automatic do_cmd(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d,
                        output int lat);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_src = s; cmd_dst = d;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // ---------------- directed sequence ----------------
  int lat;
  int gap;
  logic seen_done;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_src = 3'd0; cmd_dst = 3'd0;
    ld_en = 1'b0; ld_addr = 3'd0; ld_val = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_holds", {HOLD_OUT_A, HOLD_OUT_B}, 32'h0000_0000);
    reset = 1'b0;

    load(3'd1, 16'h0042); load(3'd2, 16'h1234); load(3'd3, 16'hBEEF);
    load(3'd4, 16'h00FF); load(3'd5, 16'h5555); load(3'd6, 16'hABCD);
    load(3'd7, 16'h7777);
    reg_chk = 1'b1;

    do_cmd(2'b00, 3'd3, 3'd5, lat);
    chk("mov_latency", lat, 3);
    chk("mov_r5", {16'd0, rf[5]}, 32'h0000_BEEF);
    chk("mov_r3", {16'd0, rf[3]}, 32'h0000_BEEF);
    chk("mov_hold_a", {16'd0, HOLD_OUT_A}, 32'h0000_BEEF);

    do_cmd(2'b01, 3'd2, 3'd6, lat);
    chk("swap_latency", lat, 5);
    chk("swap_r2", {16'd0, rf[2]}, 32'h0000_ABCD);
    chk("swap_r6", {16'd0, rf[6]}, 32'h0000_1234);
    chk("swap_holds", {HOLD_OUT_A, HOLD_OUT_B}, 32'h1234_ABCD);

    do_cmd(2'b10, 3'd1, 3'd4, lat);
    chk("zero_latency", lat, 3);
    chk("zero_r4", {16'd0, rf[4]}, 32'h0000_0000);

    do_cmd(2'b11, 3'd1, 3'd2, lat);
    chk("ill_latency", lat, 1);
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_r2", {16'd0, rf[2]}, 32'h0000_ABCD);

    do_cmd(2'b00, 3'd6, 3'd6, lat);
    chk("mov_same_r6", {16'd0, rf[6]}, 32'h0000_1234);

    do_cmd(2'b01, 3'd0, 3'd5, lat);
    chk("swap_r0_latency", lat, 5);
    chk("swap_r0_r5", {16'd0, rf[5]}, 32'h0000_0000);

    // back-to-back with cmd_valid held high
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_src = 3'd1; cmd_dst = 3'd2;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    cmd_src = 3'd2; cmd_dst = 3'd3;
    gap = 1;
    while (!cmd_ready && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    chk("b2b_gap", gap, 4);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_latency", lat, 3);
    chk("b2b_r2", {16'd0, rf[2]}, 32'h0000_0042);
    chk("b2b_r3", {16'd0, rf[3]}, 32'h0000_0042);

    // reset during S3 of SWAP 1<->7: S3's write to R7 lands on the reset edge
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_src = 3'd1; cmd_dst = 3'd7;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_strobes", {30'd0, GPR_in, GPR_out}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || err) seen_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, seen_done}, 32'd0);
    chk("abort_r7", {16'd0, rf[7]}, 32'h0000_0042);
    chk("abort_r1", {16'd0, rf[1]}, 32'h0000_0042);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
